// File: rtl/pulse_transmitter_edge_event_unit.sv
// Multi-channel edge event unit: per-channel synchroniser, glitch filter and
// mode-selected edge detection with one-cycle pulse, sticky flag and saturating count.
module pulse_transmitter_edge_event_unit #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           sig_in,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]           irq_en,
    input  logic [CHANNELS-1:0]           flag_clr,
    input  logic [CHANNELS-1:0]           count_clr,
    output logic [CHANNELS-1:0]           pulse_out,
    output logic [CHANNELS-1:0]           level_out,
    output logic [CHANNELS-1:0]           flag_out,
    output logic [CHANNELS*CNT_WIDTH-1:0] count_out,
    output logic                          irq_out
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   samp;
            logic                   lvl_q, lvl_d;
            logic [FW-1:0]          fcnt_q, fcnt_d;
            logic                   accept;
            logic                   evt;
            logic [1:0]             ch_mode;
            logic                   pulse_q;
            logic                   flag_q, flag_d;
            logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

            assign ch_mode = mode[2*gi +: 2];
            assign samp    = sync_q[SYNC_STAGES-1];

            if (SYNC_STAGES == 1) begin : g_sync1
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_q <= '0;
                    end else begin
                        sync_q <= sig_in[gi];
                    end
                end
            end else begin : g_syncn
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_q <= '0;
                    end else begin
                        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
                    end
                end
            end

            // A sample that returns to the accepted level drops any partial count.
            always_comb begin
                lvl_d  = lvl_q;
                fcnt_d = fcnt_q;
                accept = 1'b0;
                if (samp == lvl_q) begin
                    fcnt_d = '0;
                end else if (fcnt_q == FLAST) begin
                    lvl_d  = samp;
                    fcnt_d = '0;
                    accept = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end

            // samp equals the new level whenever a transition is accepted.
            assign evt = accept & ((samp & ch_mode[0]) | (~samp & ch_mode[1]));

            always_comb begin
                flag_d = flag_q;
                if (evt) begin
                    flag_d = 1'b1;
                end else if (flag_clr[gi]) begin
                    flag_d = 1'b0;
                end
            end

            always_comb begin
                cnt_d = cnt_q;
                if (count_clr[gi]) begin
                    cnt_d = evt ? CNT_WIDTH'(1) : '0;
                end else if (evt && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    lvl_q   <= 1'b0;
                    fcnt_q  <= '0;
                    pulse_q <= 1'b0;
                    flag_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    lvl_q   <= lvl_d;
                    fcnt_q  <= fcnt_d;
                    pulse_q <= evt;
                    flag_q  <= flag_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign pulse_out[gi]                        = pulse_q;
            assign level_out[gi]                        = lvl_q;
            assign flag_out[gi]                         = flag_q;
            assign count_out[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        end
    endgenerate

    assign irq_out = |(flag_out & irq_en);

endmodule

// File: tb/tb_pulse_transmitter_edge_event_unit.sv
// Directed bench: default-parameter instance plus a filtered, narrow-counter instance.
module tb_pulse_transmitter_edge_event_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  sig_a = '0, irq_en_a = '0, flag_clr_a = '0, count_clr_a = '0;
    logic [7:0]  mode_a = '0;
    logic [3:0]  pulse_a, level_a, flag_a;
    logic [31:0] count_a;
    logic        irq_a;

    logic [0:0]  sig_b = '0, irq_en_b = 1'b1, flag_clr_b = '0, count_clr_b = '0;
    logic [1:0]  mode_b = '0;
    logic [0:0]  pulse_b, level_b, flag_b;
    logic [1:0]  count_b;
    logic        irq_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_transmitter_edge_event_unit u_a (
        .clk(clk), .rst(rst), .sig_in(sig_a), .mode(mode_a), .irq_en(irq_en_a),
        .flag_clr(flag_clr_a), .count_clr(count_clr_a), .pulse_out(pulse_a),
        .level_out(level_a), .flag_out(flag_a), .count_out(count_a), .irq_out(irq_a)
    );

    pulse_transmitter_edge_event_unit #(
        .CHANNELS(1), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(2)
    ) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_b), .mode(mode_b), .irq_en(irq_en_b),
        .flag_clr(flag_clr_b), .count_clr(count_clr_b), .pulse_out(pulse_b),
        .level_out(level_b), .flag_out(flag_b), .count_out(count_b), .irq_out(irq_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_pulse_a", 32'(pulse_a), 32'h0);
        chk("rst_level_a", 32'(level_a), 32'h0);
        chk("rst_flag_a",  32'(flag_a),  32'h0);
        chk("rst_count_a", count_a,      32'h0);
        chk("rst_irq_a",   32'(irq_a),   32'h0);
        chk("rst_count_b", 32'(count_b), 32'h0);
        rst = 1'b0;

        // ch0 rising, latency 2
        mode_a = 8'b00_00_10_01; irq_en_a = 4'b0001; sig_a = 4'b0001;
        tick(); tick();
        chk("ch0_early_pulse", 32'(pulse_a), 32'h0);
        tick();
        chk("ch0_pulse",  32'(pulse_a), 32'h1);
        chk("ch0_flag",   32'(flag_a),  32'h1);
        chk("ch0_count",  32'(count_a[7:0]), 32'h1);
        chk("ch0_irq",    32'(irq_a),   32'h1);
        chk("ch0_level",  32'(level_a), 32'h1);
        tick();
        chk("ch0_one_cycle", 32'(pulse_a), 32'h0);
        sig_a = 4'b0000;
        tick(); tick(); tick();
        chk("ch0_fall_ignored", 32'(pulse_a), 32'h0);
        chk("ch0_level_low",    32'(level_a), 32'h0);
        chk("ch0_count_hold",   32'(count_a[7:0]), 32'h1);
        flag_clr_a = 4'b0001;
        tick();
        chk("ch0_flag_clr", 32'(flag_a), 32'h0);
        chk("ch0_irq_clr",  32'(irq_a),  32'h0);
        flag_clr_a = 4'b0000;

        // ch1 falling mode
        sig_a = 4'b0010;
        tick(); tick(); tick();
        chk("ch1_rise_ignored", 32'(pulse_a), 32'h0);
        chk("ch1_level_high",   32'(level_a), 32'h2);
        sig_a = 4'b0000;
        tick(); tick(); tick();
        chk("ch1_fall_pulse", 32'(pulse_a), 32'h2);
        chk("ch1_count",      32'(count_a[15:8]), 32'h1);
        chk("ch1_irq_masked", 32'(irq_a), 32'h0);

        // ch1 both edges, 5-cycle pulse, flag_clr vs event
        mode_a = 8'b00_00_11_01; irq_en_a = 4'b0010; count_clr_a = 4'b0010;
        tick();
        chk("ch1_count_clr", 32'(count_a[15:8]), 32'h0);
        count_clr_a = 4'b0000;
        sig_a = 4'b0010;
        tick(); tick(); tick();
        chk("ch1_both_rise", 32'(pulse_a), 32'h2);
        chk("ch1_both_cnt1", 32'(count_a[15:8]), 32'h1);
        tick(); tick();
        sig_a = 4'b0000;
        tick();
        flag_clr_a = 4'b0010;
        tick();
        chk("ch1_flag_cleared", 32'(flag_a), 32'h0);
        chk("ch1_irq_cleared",  32'(irq_a),  32'h0);
        tick();
        chk("ch1_both_fall",    32'(pulse_a), 32'h2);
        chk("ch1_evt_beats_clr", 32'(flag_a), 32'h2);
        chk("ch1_both_cnt2",    32'(count_a[15:8]), 32'h2);
        chk("ch1_irq_set",      32'(irq_a), 32'h1);
        tick();
        chk("ch1_flag_clr_next", 32'(flag_a), 32'h0);
        chk("ch1_irq_clr_next",  32'(irq_a),  32'h0);
        chk("ch1_pulse_gone",    32'(pulse_a), 32'h0);
        flag_clr_a = 4'b0000;

        // ch2 toggling every cycle, mode 11
        mode_a = 8'b00_11_11_01;
        sig_a = 4'b0100; tick();
        sig_a = 4'b0000; tick();
        sig_a = 4'b0100; tick();
        chk("ch2_toggle_e2", 32'(pulse_a), 32'h4);
        sig_a = 4'b0000; tick();
        chk("ch2_toggle_e3", 32'(pulse_a), 32'h4);
        tick();
        chk("ch2_toggle_e4", 32'(pulse_a), 32'h4);
        tick();
        chk("ch2_toggle_e5", 32'(pulse_a), 32'h4);
        tick();
        chk("ch2_toggle_e6", 32'(pulse_a), 32'h0);
        chk("ch2_count",     32'(count_a[23:16]), 32'h4);

        // filter: 3-cycle glitch rejected
        mode_b = 2'b11; sig_b = 1'b1;
        tick(); tick(); tick();
        sig_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b_glitch_pulse", 32'(pulse_b), 32'h0);
        end
        chk("b_glitch_level", 32'(level_b), 32'h0);

        // filter: 4-cycle pulse accepted, edges at e5 and e9
        sig_b = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk("b_pulse4", 32'(pulse_b), 32'((e == 5) || (e == 9)));
            if (e == 3) sig_b = 1'b0;
            if (e == 5) chk("b_level_high", 32'(level_b), 32'h1);
        end
        chk("b_level_low", 32'(level_b), 32'h0);
        chk("b_count2",    32'(count_b), 32'h2);

        // saturation at 3, then clear with simultaneous event
        mode_b = 2'b01; count_clr_b = 1'b1;
        tick();
        chk("b_count_clr", 32'(count_b), 32'h0);
        count_clr_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sig_b = 1'b1;
            repeat (4) tick();
            sig_b = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        chk("b_count_sat", 32'(count_b), 32'h3);
        sig_b = 1'b1;
        repeat (5) tick();
        count_clr_b = 1'b1;
        tick();
        chk("b_clr_evt_pulse", 32'(pulse_b), 32'h1);
        chk("b_clr_evt_count", 32'(count_b), 32'h1);
        count_clr_b = 1'b0; sig_b = 1'b0;
        repeat (6) tick();

        // reset mid-filter
        sig_b = 1'b1;
        repeat (4) tick();
        rst = 1'b1; sig_b = 1'b0;
        tick();
        chk("b_rst_pulse", 32'(pulse_b), 32'h0);
        chk("b_rst_level", 32'(level_b), 32'h0);
        chk("b_rst_count", 32'(count_b), 32'h0);
        chk("b_rst_flag",  32'(flag_b),  32'h0);
        chk("b_rst_irq",   32'(irq_b),   32'h0);
        chk("a_rst_count", count_a, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b_no_stale", 32'(pulse_b), 32'h0);
        end

        // ch3: mode off tracks level, mode change alone, held through reset
        sig_a = 4'b1000;
        tick(); tick(); tick();
        chk("ch3_off_pulse", 32'(pulse_a), 32'h0);
        chk("ch3_off_level", 32'(level_a), 32'h8);
        mode_a = 8'b01_11_11_01;
        tick();
        chk("ch3_mode_change", 32'(pulse_a), 32'h0);
        rst = 1'b1;
        tick();
        chk("ch3_rst_level", 32'(level_a), 32'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("ch3_hold_early", 32'(pulse_a), 32'h0);
        tick();
        chk("ch3_hold_pulse", 32'(pulse_a), 32'h8);
        chk("ch3_hold_count", 32'(count_a[31:24]), 32'h1);
        tick();
        chk("ch3_hold_once",  32'(pulse_a), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
